// File: rtl/adder_result_fifo.sv
// rtl/adder_result_fifo.sv - first-word-fall-through FIFO buffering adder results, drop-on-full
// Optional drop counter enabled by defining ADDER_FIFO_DROP_CNT_EN.
module adder_result_fifo #(
    parameter int G_DATA_WIDTH = 8,
    parameter int G_DEPTH      = 4,
    parameter int G_CNT_WIDTH  = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_valid,
    input  logic [G_DATA_WIDTH-1:0]   i_C,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [G_DATA_WIDTH-1:0]   o_C,
    output logic [$clog2(G_DEPTH):0]  o_count,
    output logic                      o_full,
    output logic                      o_empty,
    output logic                      o_overflow
`ifdef ADDER_FIFO_DROP_CNT_EN
    ,
    output logic [G_CNT_WIDTH-1:0]    o_drop_cnt
`endif
);

    localparam int PW = $clog2(G_DEPTH);
    localparam int CW = PW + 1;

    logic [G_DATA_WIDTH-1:0] mem [G_DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic                    push;
    logic                    pop;
    logic                    drop;

    assign o_empty = (o_count == '0);
    assign o_full  = (o_count == CW'(G_DEPTH));
    assign o_valid = !o_empty;
    assign o_C     = o_valid ? mem[rd_ptr] : '0;

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign pop  = o_valid && i_ready;
    assign push = i_valid && (!o_full || pop);
    assign drop = i_valid && o_full && !pop;

    always_ff @(posedge i_clk) begin
        if (!i_rst && push) begin
            mem[wr_ptr] <= i_C;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_count    <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                o_count <= o_count + 1'b1;
            end else if (pop && !push) begin
                o_count <= o_count - 1'b1;
            end
            if (drop) begin
                o_overflow <= 1'b1;
            end
        end
    end

`ifdef ADDER_FIFO_DROP_CNT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_drop_cnt <= '0;
        end else if (drop && (o_drop_cnt != '1)) begin
            o_drop_cnt <= o_drop_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_adder_result_fifo.sv
// tb/tb_adder_result_fifo.sv - table-driven, scoreboarded bench for adder_result_fifo
module tb_adder_result_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CNTW  = 16;

    logic                     i_clk = 1'b0;
    logic                     i_rst;
    logic                     i_valid;
    logic [DW-1:0]            i_C;
    logic                     o_valid;
    logic                     i_ready;
    logic [DW-1:0]            o_C;
    logic [$clog2(DEPTH):0]   o_count;
    logic                     o_full;
    logic                     o_empty;
    logic                     o_overflow;
`ifdef ADDER_FIFO_DROP_CNT_EN
    logic [CNTW-1:0]          o_drop_cnt;
`endif

    adder_result_fifo #(
        .G_DATA_WIDTH(DW),
        .G_DEPTH     (DEPTH),
        .G_CNT_WIDTH (CNTW)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .i_C        (i_C),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_C        (o_C),
        .o_count    (o_count),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_overflow (o_overflow)
`ifdef ADDER_FIFO_DROP_CNT_EN
        ,
        .o_drop_cnt (o_drop_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic          v;
        logic [DW-1:0] c;
        logic          r;
        int            exp_cnt;
        logic          exp_ovf;
    } vec_t;

    vec_t          vecs[$];
    logic [DW-1:0] sb[$];
    logic          m_ovf;
    int            m_drop;
    int            n_checks;
    int            n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic v, input logic [DW-1:0] c, input logic r,
                                input int cnt, input logic ovf);
        vec_t t;
        t.v = v; t.c = c; t.r = r; t.exp_cnt = cnt; t.exp_ovf = ovf;
        vecs.push_back(t);
    endfunction

    task automatic check_state();
        int sz;
        sz = sb.size();
        chk("count",    32'(o_count),    32'(sz));
        chk("valid",    32'(o_valid),    32'(sz > 0));
        chk("empty",    32'(o_empty),    32'(sz == 0));
        chk("full",     32'(o_full),     32'(sz == DEPTH));
        chk("overflow", 32'(o_overflow), 32'(m_ovf));
        chk("data",     32'(o_C),        (sz > 0) ? 32'(sb[0]) : 32'h0);
`ifdef ADDER_FIFO_DROP_CNT_EN
        chk("drop_cnt", 32'(o_drop_cnt), 32'(m_drop));
`endif
    endtask

    // Called at a falling edge: drive, check current state, advance the model, wait one cycle.
    task automatic cycle(input logic v, input logic [DW-1:0] c, input logic r);
        logic pop_m;
        logic full_m;
        i_valid = v;
        i_C     = c;
        i_ready = r;
        check_state();
        pop_m  = (sb.size() > 0) && r;
        full_m = (sb.size() == DEPTH);
        if (pop_m) void'(sb.pop_front());
        if (v && (!full_m || pop_m)) begin
            sb.push_back(c);
        end else if (v) begin
            m_ovf = 1'b1;
            if (m_drop < (1 << CNTW) - 1) m_drop++;
        end
        @(negedge i_clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_ovf    = 1'b0;
        m_drop   = 0;
        i_rst    = 1'b1;
        i_valid  = 1'b0;
        i_C      = '0;
        i_ready  = 1'b0;

        // basic flow
        add(1, 8'h11, 0, 1, 0); add(1, 8'h22, 0, 2, 0); add(1, 8'h33, 0, 3, 0);
        add(0, 8'h00, 1, 2, 0); add(0, 8'h00, 1, 1, 0); add(0, 8'h00, 1, 0, 0);
        // fill and overflow
        for (int k = 1; k <= 4; k++) add(1, 8'(k), 0, k, 0);
        add(1, 8'h05, 0, 4, 1);
        for (int k = 3; k >= 0; k--) add(0, 8'h00, 1, k, 1);
        // full with simultaneous push and pop
        for (int k = 0; k < 4; k++) add(1, 8'hA0 + 8'(k), 0, k + 1, 1);
        add(1, 8'hA4, 1, 4, 1);
        for (int k = 3; k >= 0; k--) add(0, 8'h00, 1, k, 1);
        // wrap-around streaming
        for (int k = 0; k < 10; k++) add(1, 8'(k), 1, 1, 1);
        add(0, 8'h00, 1, 0, 1);

        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        check_state();
        cycle(0, 8'h00, 1);

        foreach (vecs[i]) begin
            cycle(vecs[i].v, vecs[i].c, vecs[i].r);
            chk($sformatf("vec%0d_count", i), 32'(o_count), 32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_ovf", i), 32'(o_overflow), 32'(vecs[i].exp_ovf));
        end

        // reset mid-operation with a push presented in the reset cycle
        cycle(1, 8'hC1, 0);
        cycle(1, 8'hC2, 0);
        cycle(1, 8'hC3, 0);
        check_state();
        i_rst   = 1'b1;
        i_valid = 1'b1;
        i_C     = 8'hEE;
        i_ready = 1'b1;
        @(negedge i_clk);
        i_rst   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        sb.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
        chk("rst_count", 32'(o_count), 32'h0);
        chk("rst_ovf",   32'(o_overflow), 32'h0);
        chk("rst_valid", 32'(o_valid), 32'h0);
        chk("rst_data",  32'(o_C), 32'h0);
        cycle(0, 8'h00, 1);
        cycle(1, 8'h5A, 0);
        chk("post_rst_head", 32'(o_C), 32'h5A);
        cycle(0, 8'h00, 1);
        cycle(0, 8'h00, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_result_fifo.md
# adder_result_fifo

Buffers the results of the `adder` block and hands them downstream with a valid/ready handshake. The adder has no backpressure input, so every result is either stored or, when the FIFO is full, dropped and flagged. It sits directly after `adder`, with its `i_valid`/`i_C` wired to the adder's `o_valid`/`o_C`. It is first-word-fall-through: the head entry is always presented on `o_C`.

## Interface
- `G_DATA_WIDTH`, 8: result width; must match the adder.
- `G_DEPTH`, 4: number of entries; a power of two, ≥ 2.
- `G_CNT_WIDTH`, 16: width of the drop counter. Used only when `ADDER_FIFO_DROP_CNT_EN` is defined.

Ports:
- `i_clk`, in, 1: the single clock; all logic updates on its rising edge.
- `i_rst`, in, 1: synchronous reset, active-high.
- `i_valid`, in, 1: the adder result on `i_C` is valid this cycle.
- `i_C`, in, `G_DATA_WIDTH`: adder result.
- `o_valid`, out, 1: a head entry is available.
- `i_ready`, in, 1: downstream accepts the head entry this cycle.
- `o_C`, out, `G_DATA_WIDTH`: head entry; reads as 0 when `o_valid`=0.
- `o_count`, out, `$clog2(G_DEPTH)+1`: current occupancy.
- `o_full`, out, 1: `o_count` == `G_DEPTH`.
- `o_empty`, out, 1: `o_count` == 0.
- `o_overflow`, out, 1: sticky; set by the first dropped result.
- `o_drop_cnt`, out, `G_CNT_WIDTH`: number of dropped results. Present only when `ADDER_FIFO_DROP_CNT_EN` is defined.

## Operation
- Storage: `G_DEPTH`-entry array, with write pointer `wr_ptr` and read pointer `rd_ptr`, each `$clog2(G_DEPTH)` bits. Pointers wrap naturally from `G_DEPTH`-1 to 0.
- Pop: `pop = o_valid && i_ready`. A pop advances `rd_ptr`.
- Push: `push = i_valid && (!o_full || pop)`. A push writes `i_C` at `wr_ptr` and advances `wr_ptr`.
  - When full, a push in the same cycle as a pop is accepted, because the pop frees a slot.
- Drop: `drop = i_valid && o_full && !pop`.
  - The data is discarded and the pointers are unchanged.
  - `o_overflow` is set to 1 and stays set until reset.
- Count: `o_count` increments on push only, decrements on pop only, and is unchanged on push+pop or on neither.
- Empty FIFO: `o_valid`=0, so no pop is possible. A push into an empty FIFO is not bypassed to `o_C` in the same cycle.
- Flags: `o_valid` = !`o_empty`.
  - `o_full` and `o_empty` are decoded from the `o_count` register; no combinational path from `i_valid` or `i_ready`.
- Data output: `o_C` = array[`rd_ptr`] when `o_valid`=1, otherwise 0.
- Reset (`i_rst`=1 at a rising edge): `wr_ptr`, `rd_ptr` and `o_count` go to 0, `o_overflow` goes to 0, and `o_drop_cnt` (if present) goes to 0.
  - Push, pop and drop are all ignored in the reset cycle.
  - Array contents are not reset.
  - Reset in the middle of operation discards all stored entries.
- Reset values of outputs: `o_valid`=0, `o_C`=0, `o_count`=0, `o_full`=0, `o_empty`=1, `o_overflow`=0, `o_drop_cnt`=0.

## Timing
- Push to visible latency: a result pushed at edge N is on `o_C` with `o_valid`=1 after edge N (the next cycle).
- `o_count`, `o_full` and `o_empty` reflect all pushes and pops up to and including the most recent edge.
- Throughput: one push and one pop per cycle, sustained, at any fill level.
- `i_ready` may change freely. `o_valid` never deasserts without a pop or a reset.
- `o_C` is stable while `o_valid`=1 and `i_ready`=0.

## Configuration
- `ADDER_FIFO_DROP_CNT_EN` defined:
  - Adds the `o_drop_cnt` port.
  - The counter increments by 1 on each drop and saturates at 2^`G_CNT_WIDTH`-1 (it does not wrap).
- `ADDER_FIFO_DROP_CNT_EN` undefined:
  - The port and the counter are absent.
  - Drops are reported only through `o_overflow`.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then idle: `o_valid`=0, `o_empty`=1, `o_count`=0, `o_C`=0.
- Basic flow: push 0x11, 0x22, 0x33 on consecutive cycles with `i_ready`=0.
  - Required: `o_count`=3 and `o_C`=0x11.
  - Then raise `i_ready`: pops 0x11, 0x22, 0x33 in order, then `o_empty`=1.
- Fill and overflow (`G_DEPTH`=4): push 0x01..0x04 with `i_ready`=0, giving `o_full`=1.
  - Push 0x05: it is dropped, `o_overflow`=1, `o_drop_cnt`=1, `o_count` stays 4.
  - Draining returns 0x01..0x04.
- Full with simultaneous push and pop: FIFO holds 0xA0..0xA3; push 0xA4 while `i_ready`=1.
  - Required: no drop, `o_count` stays 4, and the next four pops return 0xA1..0xA4.
- Wrap-around: 10 cycles of continuous push and pop of 0x00..0x09 with `i_ready`=1.
  - Required: outputs 0x00..0x09, each one cycle after its push; `o_count` ≤ 1; no drop.
- Reset mid-operation: with 3 entries stored and `o_overflow`=1, assert `i_rst` for 1 cycle while `i_valid`=1.
  - Required: `o_count`=0, `o_overflow`=0, `o_drop_cnt`=0, and the push in the reset cycle is not stored.
